// File: rtl/vai_arb_pkg.sv
// Purpose : shared constants, requester-id type and round-robin pick function for the c0 arbiter.
// Latency : n/a (package, combinational helper only).
// Backpr. : n/a.
// Ports   : none. Optional grant statistics are enabled by VAI_C0_ARB_STATS_EN in the top.
package vai_arb_pkg;

    localparam int DEF_NUM_SUB_AFUS  = 4;
    localparam int DEF_HDR_W         = 74;
    localparam int DEF_FIFO_DEPTH    = 8;
    localparam int DEF_ALMFULL_SLACK = 4;
    localparam int STAT_W            = 32;
    // Widest requester count the pick function handles.
    localparam int MAX_REQ           = 16;

    typedef logic [$clog2(DEF_NUM_SUB_AFUS)-1:0] t_arb_id;

    // Returns {found, index}: first set bit of cand searching upward from
    // last+1 and wrapping modulo n. n is a constant at every call site, so
    // the modulo folds away in synthesis.
    function automatic logic [4:0] rr_next_grant(
        input logic [MAX_REQ-1:0] cand,
        input logic [3:0]         last,
        input int                 n
    );
        logic [4:0] pick;
        logic [3:0] idx;
        pick = '0;
        idx  = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            idx = 4'((int'(last) + k) % n);
            if (k <= n && !pick[4] && cand[idx]) begin
                pick = {1'b1, idx};
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/vai_arb_fifo.sv
// Purpose : single-requester header FIFO feeding the c0 round-robin scheduler.
// Latency : a push is visible at head/empty on the next cycle.
// Backpr. : push on full is dropped (full judged before same-cycle pop); almfull is registered.
// Ports   : clk, rst (async active-high), push/push_hdr in, pop in, head/full/empty/almfull out.
module vai_arb_fifo
    import vai_arb_pkg::*;
#(
    parameter int W     = DEF_HDR_W,
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int SLACK = DEF_ALMFULL_SLACK
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_hdr,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty,
    output logic         almfull
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] occ_next;
    logic             do_push;
    logic             do_pop;

    assign full    = (occ == OCC_W'(DEPTH));
    assign empty   = (occ == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_comb begin
        occ_next = occ + OCC_W'(do_push) - OCC_W'(do_pop);
    end

    // Storage carries no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_hdr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            almfull <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            occ     <= occ_next;
            almfull <= (occ_next >= OCC_W'(DEPTH - SLACK));
        end
    end

endmodule

// File: rtl/vai_c0_arbiter.sv
// Purpose : round-robin share of the upstream CCI-P c0 read-request channel among sub-AFUs.
// Latency : push at t -> out_valid at t+2 when uncontended; one grant per cycle aggregate.
// Backpr. : up_almfull stalls all grants; per-requester req_almfull is registered, overflow drops are sticky.
// Ports   : pClk, SoftReset (async active-high); req_valid/req_hdr in, req_almfull/err_overflow out;
//           up_almfull in; out_valid/out_hdr/out_id out; stat_grants out (counters built only
//           when VAI_C0_ARB_STATS_EN is defined, otherwise tied to zero).
module vai_c0_arbiter
    import vai_arb_pkg::*;
#(
    parameter int NUM_SUB_AFUS  = DEF_NUM_SUB_AFUS,
    parameter int HDR_W         = DEF_HDR_W,
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
    parameter int ALMFULL_SLACK = DEF_ALMFULL_SLACK,
    parameter int ID_W          = $clog2(NUM_SUB_AFUS)
) (
    input  logic                                   pClk,
    input  logic                                   SoftReset,
    input  logic [NUM_SUB_AFUS-1:0]                req_valid,
    input  logic [NUM_SUB_AFUS-1:0][HDR_W-1:0]     req_hdr,
    output logic [NUM_SUB_AFUS-1:0]                req_almfull,
    output logic [NUM_SUB_AFUS-1:0]                err_overflow,
    input  logic                                   up_almfull,
    output logic                                   out_valid,
    output logic [HDR_W-1:0]                       out_hdr,
    output logic [ID_W-1:0]                        out_id,
    output logic [NUM_SUB_AFUS-1:0][STAT_W-1:0]    stat_grants
);

    logic [NUM_SUB_AFUS-1:0] fifo_empty;
    logic [NUM_SUB_AFUS-1:0] fifo_full;
    logic [NUM_SUB_AFUS-1:0] pop;
    logic [HDR_W-1:0]        heads [NUM_SUB_AFUS];
    logic [MAX_REQ-1:0]      cand;
    logic [4:0]              pick;
    logic                    grant_vld;
    logic [ID_W-1:0]         grant_id;
    logic [ID_W-1:0]         last_grant;

    for (genvar i = 0; i < NUM_SUB_AFUS; i++) begin : g_fifo
        vai_arb_fifo #(
            .W     (HDR_W),
            .DEPTH (FIFO_DEPTH),
            .SLACK (ALMFULL_SLACK)
        ) u_fifo (
            .clk      (pClk),
            .rst      (SoftReset),
            .push     (req_valid[i]),
            .push_hdr (req_hdr[i]),
            .pop      (pop[i]),
            .head     (heads[i]),
            .full     (fifo_full[i]),
            .empty    (fifo_empty[i]),
            .almfull  (req_almfull[i])
        );
    end

    // Candidates use start-of-cycle occupancy, so a same-cycle push is not grantable yet.
    always_comb begin
        cand                     = '0;
        cand[NUM_SUB_AFUS-1:0]   = up_almfull ? '0 : ~fifo_empty;
        pick                     = rr_next_grant(cand, 4'(last_grant), NUM_SUB_AFUS);
        grant_vld                = pick[4];
        grant_id                 = ID_W'(pick[3:0]);
        pop                      = '0;
        if (grant_vld) begin
            pop[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge pClk or posedge SoftReset) begin
        if (SoftReset) begin
            out_valid    <= 1'b0;
            out_hdr      <= '0;
            out_id       <= '0;
            last_grant   <= ID_W'(NUM_SUB_AFUS - 1);
            err_overflow <= '0;
        end else begin
            out_valid <= grant_vld;
            if (grant_vld) begin
                out_hdr    <= heads[grant_id];
                out_id     <= grant_id;
                last_grant <= grant_id;
            end
            err_overflow <= err_overflow | (req_valid & fifo_full);
        end
    end

`ifdef VAI_C0_ARB_STATS_EN
    always_ff @(posedge pClk or posedge SoftReset) begin
        if (SoftReset) begin
            stat_grants <= '0;
        end else if (grant_vld && (stat_grants[grant_id] != '1)) begin
            stat_grants[grant_id] <= stat_grants[grant_id] + STAT_W'(1);
        end
    end
`else
    assign stat_grants = '0;
`endif

endmodule

// File: tb/tb_vai_c0_arbiter.sv
// Purpose : randomized bench for vai_c0_arbiter against a queue-based behavioural model.
// Latency : checks every cycle, 1 time unit after the rising edge.
// Backpr. : drives up_almfull patterns and over-subscribes FIFOs to exercise drop/almfull paths.
module tb_vai_c0_arbiter;

    localparam int N     = 4;
    localparam int HDR_W = 74;
    localparam int DEPTH = 8;
    localparam int SLACK = 4;
    localparam int ID_W  = 2;

    logic                       pClk = 1'b0;
    logic                       SoftReset;
    logic [N-1:0]               req_valid;
    logic [N-1:0][HDR_W-1:0]    req_hdr;
    logic [N-1:0]               req_almfull;
    logic [N-1:0]               err_overflow;
    logic                       up_almfull;
    logic                       out_valid;
    logic [HDR_W-1:0]           out_hdr;
    logic [ID_W-1:0]            out_id;
    logic [N-1:0][31:0]         stat_grants;

    vai_c0_arbiter dut (
        .pClk         (pClk),
        .SoftReset    (SoftReset),
        .req_valid    (req_valid),
        .req_hdr      (req_hdr),
        .req_almfull  (req_almfull),
        .err_overflow (err_overflow),
        .up_almfull   (up_almfull),
        .out_valid    (out_valid),
        .out_hdr      (out_hdr),
        .out_id       (out_id),
        .stat_grants  (stat_grants)
    );

    always #5 pClk = ~pClk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: one queue per requester plus the expected output registers.
    logic [HDR_W-1:0] q [N][$];
    int               m_last;
    logic             m_valid;
    logic [HDR_W-1:0] m_hdr;
    logic [ID_W-1:0]  m_id;
    logic [N-1:0]     m_alm;
    logic [N-1:0]     m_ovf;
    longint           m_grants [N];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [HDR_W-1:0] rand_hdr();
        return HDR_W'({$urandom, $urandom, $urandom});
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            q[i].delete();
            m_grants[i] = 0;
        end
        m_last  = N - 1;
        m_valid = 1'b0;
        m_hdr   = '0;
        m_id    = '0;
        m_alm   = '0;
        m_ovf   = '0;
    endtask

    task automatic check_outputs();
        logic [31:0] exp_stat;
        chk("out_valid", 128'(out_valid), 128'(m_valid));
        chk("out_hdr", 128'(out_hdr), 128'(m_hdr));
        chk("out_id", 128'(out_id), 128'(m_id));
        chk("req_almfull", 128'(req_almfull), 128'(m_alm));
        chk("err_overflow", 128'(err_overflow), 128'(m_ovf));
        for (int i = 0; i < N; i++) begin
`ifdef VAI_C0_ARB_STATS_EN
            exp_stat = (m_grants[i] > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(m_grants[i]);
`else
            exp_stat = 32'd0;
`endif
            chk($sformatf("stat_grants[%0d]", i), 128'(stat_grants[i]), 128'(exp_stat));
        end
    endtask

    // One clock cycle: drive at the falling edge, advance the model, check after the rising edge.
    task automatic do_cycle(input logic [N-1:0] vld, input logic ua);
        logic [N-1:0][HDR_W-1:0] h;
        int sz [N];
        int g;
        @(negedge pClk);
        for (int i = 0; i < N; i++) begin
            h[i]  = rand_hdr();
            sz[i] = q[i].size();
        end
        req_valid  = vld;
        req_hdr    = h;
        up_almfull = ua;

        g = -1;
        if (!ua) begin
            for (int k = 1; k <= N; k++) begin
                if (g < 0 && sz[(m_last + k) % N] > 0) g = (m_last + k) % N;
            end
        end
        if (g >= 0) begin
            m_valid = 1'b1;
            m_hdr   = q[g].pop_front();
            m_id    = ID_W'(g);
            m_last  = g;
            m_grants[g]++;
        end else begin
            m_valid = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (vld[i]) begin
                if (sz[i] == DEPTH) m_ovf[i] = 1'b1;
                else q[i].push_back(h[i]);
            end
            m_alm[i] = (q[i].size() >= DEPTH - SLACK);
        end

        @(posedge pClk);
        #1;
        check_outputs();
    endtask

    // Asynchronous reset asserted between edges; outputs must clear before any clock.
    task automatic apply_reset();
        @(negedge pClk);
        SoftReset  = 1'b1;
        req_valid  = '0;
        up_almfull = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge pClk);
        SoftReset = 1'b0;
    endtask

    initial begin
        logic [N-1:0] v;
        int ua_pct;
        int dens;

        SoftReset  = 1'b1;
        req_valid  = '0;
        req_hdr    = '0;
        up_almfull = 1'b0;
        model_reset();
        #12;
        check_outputs();
        @(negedge pClk);
        SoftReset = 1'b0;

        // Single push on requester 2: one beat two cycles later.
        do_cycle(4'b0100, 1'b0);
        repeat (4) do_cycle('0, 1'b0);

        // All requesters busy: strict 0,1,2,3 rotation, per-requester order kept.
        apply_reset();
        repeat (16) do_cycle(4'hF, 1'b0);
        repeat (40) do_cycle('0, 1'b0);

        // Fill requester 0 past depth while upstream is almost-full, then drain.
        apply_reset();
        repeat (9) do_cycle(4'b0001, 1'b1);
        repeat (2) do_cycle('0, 1'b1);
        repeat (12) do_cycle('0, 1'b0);

        // Upstream almost-full toggling every other cycle with queued traffic.
        apply_reset();
        for (int i = 0; i < 24; i++) begin
            v = (i < 8) ? N'($urandom) : '0;
            do_cycle(v, 1'(i % 2));
        end
        repeat (12) do_cycle('0, 1'b0);

        // Reset with headers queued and a beat in flight; nothing emitted afterwards.
        apply_reset();
        do_cycle(4'b1011, 1'b1);
        do_cycle(4'b0011, 1'b1);
        do_cycle('0, 1'b0);
        apply_reset();
        repeat (4) do_cycle('0, 1'b0);
        do_cycle(4'hF, 1'b0);
        repeat (6) do_cycle('0, 1'b0);

        // Grant counters: ten grants to requester 1, three to requester 3.
        apply_reset();
        for (int i = 0; i < 10; i++) do_cycle((i < 3) ? 4'b1010 : 4'b0010, 1'b0);
        repeat (6) do_cycle('0, 1'b0);

        // Randomized traffic with varying density and upstream pressure.
        apply_reset();
        for (int e = 0; e < 6; e++) begin
            ua_pct = $urandom_range(0, 70);
            dens   = $urandom_range(0, 2);
            for (int c = 0; c < 400; c++) begin
                v = N'($urandom);
                for (int d = 0; d < dens; d++) v = v & N'($urandom);
                do_cycle(v, 1'($urandom_range(0, 99) < ua_pct));
                if ($urandom_range(0, 499) == 0) apply_reset();
            end
            repeat (40) do_cycle('0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
